// File: rtl/pipe_stall_pkg.sv
// Shared pipeline definitions for the stall controller: MD start encodings,
// busy-timer state encoding, the "operand unused" Tuse value and the
// per-operand hazard comparator used by the top level.
package pipe_stall_pkg;

   // Encoding of the EX-stage multiply/divide start request.
   typedef enum logic [1:0] {
      MD_NONE = 2'b00,
      MD_MULT = 2'b01,
      MD_DIV  = 2'b10,
      MD_RSVD = 2'b11
   } md_start_e;

   // Busy-timer states.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // Tuse value meaning "this source operand is not read".
   localparam logic [1:0] TUSE_UNUSED = 2'd3;

   // True when a source operand needs a value that EX or MEM will not have
   // ready in time. Register 0 never hazards because it is hard-wired.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] ex_dst,
      input logic [1:0] ex_tnew,
      input logic [4:0] mem_dst,
      input logic [1:0] mem_tnew
   );
      logic hit;
      hit = 1'b0;
      if ((src != 5'd0) && (tuse != TUSE_UNUSED)) begin
         hit = ((src == ex_dst)  && (ex_tnew  > tuse)) ||
               ((src == mem_dst) && (mem_tnew > tuse));
      end else begin
         hit = 1'b0;
      end
      return hit;
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: counts down the fixed latency of the
// operation started in EX and flags any start request that arrives while
// the unit is still occupied.
module md_busy_timer
   import pipe_stall_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] md_start_i,
   output logic       md_busy_o,
   output logic       md_err_o
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_busy_q, md_busy_d;
   logic             md_err_q, md_err_d;
   logic             start_mult_s;
   logic             start_div_s;

   assign start_mult_s = (md_start_i == MD_MULT);
   assign start_div_s  = (md_start_i == MD_DIV);

   // Next-state logic: load on start in IDLE, count down in BUSY, flag restarts.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_err_d = md_err_q;
      case (state_q)
         ST_IDLE: begin
            if (start_mult_s) begin
               state_d = ST_BUSY;
               cnt_d   = MULT_LOAD;
            end else if (start_div_s) begin
               state_d = ST_BUSY;
               cnt_d   = DIV_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (start_mult_s || start_div_s) begin
               md_err_d = 1'b1;
            end else begin
               md_err_d = md_err_q;
            end
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      md_busy_d = (state_d == ST_BUSY);
   end

   // State, counter and flag registers; reset aborts any operation at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         md_busy_q <= 1'b0;
         md_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         md_busy_q <= md_busy_d;
         md_err_q  <= md_err_d;
      end
   end

   assign md_busy_o = md_busy_q;
   assign md_err_o  = md_err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data-hazard detection, MD-unit
// structural hazard, bubble insertion and a saturating stall counter.
module pipe_stall_ctrl
   import pipe_stall_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [1:0]  id_rs_tuse,
   input  logic [1:0]  id_rt_tuse,
   input  logic        id_is_md,
   input  logic [4:0]  ex_dst,
   input  logic [1:0]  ex_tnew,
   input  logic [4:0]  mem_dst,
   input  logic [1:0]  mem_tnew,
   input  logic [1:0]  ex_md_start,
   output logic        stall,
   output logic        id_ex_flush,
   output logic        md_busy,
   output logic        md_err,
   output logic [15:0] stall_cnt
);

   logic        rs_hazard_s;
   logic        rt_hazard_s;
   logic        md_hazard_s;
   logic        stall_s;
   logic        md_busy_s;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_timer (
      .clk        (clk),
      .reset      (reset),
      .md_start_i (ex_md_start),
      .md_busy_o  (md_busy_s),
      .md_err_o   (md_err)
   );

   // Hazard combination: stall must act in the same cycle the ID instruction is seen.
   always_comb begin
      rs_hazard_s = src_hazard(id_rs, id_rs_tuse, ex_dst, ex_tnew, mem_dst, mem_tnew);
      rt_hazard_s = src_hazard(id_rt, id_rt_tuse, ex_dst, ex_tnew, mem_dst, mem_tnew);
      md_hazard_s = 1'b0;
      if (id_is_md) begin
         md_hazard_s = md_busy_s || (ex_md_start == MD_MULT) || (ex_md_start == MD_DIV);
      end else begin
         md_hazard_s = 1'b0;
      end
      stall_s = rs_hazard_s | rt_hazard_s | md_hazard_s;
   end

   // Saturating stall-cycle counter next value.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall       = stall_s;
   assign id_ex_flush = stall_s;
   assign md_busy     = md_busy_s;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
   logic [1:0]  id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew, ex_md_start;
   logic        id_is_md;
   logic        stall, id_ex_flush, md_busy, md_err;
   logic [15:0] stall_cnt;

   int n_vec;
   int n_err;

   // reference model state: remaining busy cycles, sticky error, stall count
   int m_left;
   int m_err;
   int m_cnt;

   pipe_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rs_tuse  (id_rs_tuse),
      .id_rt_tuse  (id_rt_tuse),
      .id_is_md    (id_is_md),
      .ex_dst      (ex_dst),
      .ex_tnew     (ex_tnew),
      .mem_dst     (mem_dst),
      .mem_tnew    (mem_tnew),
      .ex_md_start (ex_md_start),
      .stall       (stall),
      .id_ex_flush (id_ex_flush),
      .md_busy     (md_busy),
      .md_err      (md_err),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit ref_src_haz(int r, int tuse, int ed, int et, int md, int mt);
      if (r == 0 || tuse == 3) return 1'b0;
      return ((r == ed) && (et > tuse)) || ((r == md) && (mt > tuse));
   endfunction

   function automatic bit ref_stall();
      bit md_req;
      md_req = (ex_md_start == 2'd1) || (ex_md_start == 2'd2);
      return ref_src_haz(id_rs, id_rs_tuse, ex_dst, ex_tnew, mem_dst, mem_tnew) ||
             ref_src_haz(id_rt, id_rt_tuse, ex_dst, ex_tnew, mem_dst, mem_tnew) ||
             (id_is_md && ((m_left > 0) || md_req));
   endfunction

   task automatic model_reset();
      m_left = 0;
      m_err  = 0;
      m_cnt  = 0;
   endtask

   task automatic quiet_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_rs_tuse = 2'd3; id_rt_tuse = 2'd3;
      id_is_md = 1'b0; ex_dst = 5'd0; ex_tnew = 2'd0; mem_dst = 5'd0;
      mem_tnew = 2'd0; ex_md_start = 2'd0;
   endtask

   // one clock: optionally compare all outputs, then advance the model at the edge
   task automatic step(input bit do_check);
      bit exp_stall;
      bit md_req;
      #1;
      exp_stall = ref_stall();
      if (do_check) begin
         check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
         check_val("flush", {31'd0, id_ex_flush}, {31'd0, exp_stall});
         check_val("md_busy", {31'd0, md_busy}, (m_left > 0) ? 32'd1 : 32'd0);
         check_val("md_err", {31'd0, md_err}, m_err);
         check_val("stall_cnt", {16'd0, stall_cnt}, m_cnt);
      end
      @(posedge clk);
      if (reset) begin
         md_req = (ex_md_start == 2'd1) || (ex_md_start == 2'd2);
         if (exp_stall && m_cnt < 65535) m_cnt++;
         if (m_left > 0) begin
            if (md_req) m_err = 1;
            m_left--;
         end else if (ex_md_start == 2'd1) begin
            m_left = MULT_N;
         end else if (ex_md_start == 2'd2) begin
            m_left = DIV_N;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      quiet_inputs();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      check_val("rst_busy", {31'd0, md_busy}, 32'd0);
      check_val("rst_err", {31'd0, md_err}, 32'd0);
      check_val("rst_cnt", {16'd0, stall_cnt}, 32'd0);
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      step(1'b1);
      reset = 1'b1;
      step(1'b1);

      // load-use: producer in EX ready in 2, consumer needs rs in 1
      ex_dst = 5'd5; ex_tnew = 2'd2; id_rs = 5'd5; id_rs_tuse = 2'd1;
      #1;
      check_val("lu_stall", {31'd0, stall}, 32'd1);
      check_val("lu_flush", {31'd0, id_ex_flush}, 32'd1);
      step(1'b1);
      #1;
      check_val("lu_cnt", {16'd0, stall_cnt}, 32'd1);
      quiet_inputs();
      step(1'b1);

      // register 0 never creates a hazard
      id_rs = 5'd0; id_rs_tuse = 2'd0; ex_dst = 5'd0; ex_tnew = 2'd2;
      #1;
      check_val("r0_stall", {31'd0, stall}, 32'd0);
      step(1'b1);

      // mult timing with an MD instruction waiting in ID
      quiet_inputs();
      id_is_md = 1'b1; ex_md_start = 2'd1;
      step(1'b1);
      ex_md_start = 2'd0;
      for (int i = 1; i <= MULT_N + 1; i++) begin
         #1;
         check_val("mult_busy", {31'd0, md_busy}, (i <= MULT_N) ? 32'd1 : 32'd0);
         check_val("mult_stall", {31'd0, stall}, (i <= MULT_N) ? 32'd1 : 32'd0);
         step(1'b1);
      end

      // restart while busy: no reload, sticky error
      quiet_inputs();
      ex_md_start = 2'd2;
      step(1'b1);
      ex_md_start = 2'd0;
      step(1'b1);
      step(1'b1);
      ex_md_start = 2'd2;
      step(1'b1);
      ex_md_start = 2'd0;
      for (int i = 4; i <= DIV_N + 2; i++) begin
         #1;
         check_val("rs_busy", {31'd0, md_busy}, (i <= DIV_N) ? 32'd1 : 32'd0);
         check_val("rs_err", {31'd0, md_err}, 32'd1);
         step(1'b1);
      end

      // asynchronous reset in the middle of a divide
      ex_md_start = 2'd2;
      step(1'b1);
      ex_md_start = 2'd0;
      step(1'b1);
      step(1'b1);
      #1;
      check_val("ar_pre_busy", {31'd0, md_busy}, 32'd1);
      reset = 1'b0;
      model_reset();
      #1;
      check_val("ar_busy", {31'd0, md_busy}, 32'd0);
      check_val("ar_err", {31'd0, md_err}, 32'd0);
      check_val("ar_cnt", {16'd0, stall_cnt}, 32'd0);
      step(1'b1);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
      end

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         id_rs_tuse  = 2'($urandom_range(0, 3));
         id_rt_tuse  = 2'($urandom_range(0, 3));
         id_is_md    = 1'($urandom_range(0, 1));
         ex_dst      = 5'($urandom_range(0, 3));
         ex_tnew     = 2'($urandom_range(0, 3));
         mem_dst     = 5'($urandom_range(0, 3));
         mem_tnew    = 2'($urandom_range(0, 3));
         ex_md_start = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         step(1'b1);
      end

      // saturation: hold a data hazard well past 65535 cycles
      quiet_inputs();
      ex_dst = 5'd7; ex_tnew = 2'd2; id_rs = 5'd7; id_rs_tuse = 2'd0;
      for (int i = 0; i < 70000; i++) begin
         step(1'b0);
      end
      #1;
      check_val("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
      step(1'b1);
      #1;
      check_val("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles of the mult/multu operation.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles of the div/divu operation.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_rs  input  5  rs register number of the ID-stage instruction.
REQ-006 SHALL have port id_rt  input  5  rt register number of the ID-stage instruction.
REQ-007 SHALL have port id_rs_tuse  input  2  cycles until rs is needed (0..2); 3 = rs unused.
REQ-008 SHALL have port id_rt_tuse  input  2  cycles until rt is needed (0..2); 3 = rt unused.
REQ-009 SHALL have port id_is_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port ex_dst  input  5  destination register of the EX-stage instruction; 0 = none.
REQ-011 SHALL have port ex_tnew  input  2  cycles until the EX result is ready.
REQ-012 SHALL have port mem_dst  input  5  destination register of the MEM-stage instruction; 0 = none.
REQ-013 SHALL have port mem_tnew  input  2  cycles until the MEM result is ready.
REQ-014 SHALL have port ex_md_start  input  2  00 none, 01 mult, 10 div, 11 reserved (treated as none).
REQ-015 SHALL have port stall  output  1  freezes the PC and IF/ID registers.
REQ-016 SHALL have port id_ex_flush  output  1  loads a bubble into ID/EX.
REQ-017 SHALL have port md_busy  output  1  MD unit is occupied.
REQ-018 SHALL have port md_err  output  1  sticky flag: start received while busy.
REQ-019 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-020 SHALL assert rs_hazard when id_rs!=0, id_rs_tuse!=3, and one of these holds:
- id_rs==ex_dst and ex_tnew>id_rs_tuse
- id_rs==mem_dst and mem_tnew>id_rs_tuse
REQ-021 SHALL compute rt_hazard identically to REQ-020 using id_rt and id_rt_tuse.
REQ-022 SHALL assert md_hazard when id_is_md=1 and either md_busy=1 or ex_md_start is 01 or 10.
REQ-023 SHALL drive stall = rs_hazard | rt_hazard | md_hazard, combinationally in the same cycle.
REQ-024 SHALL drive id_ex_flush equal to stall.
REQ-025 SHALL implement an FSM with states IDLE and BUSY and a down-counter cnt.
REQ-026 SHALL, in IDLE with a valid ex_md_start, go to BUSY and load cnt = MULT_CYCLES-1 (mult) or DIV_CYCLES-1 (div).
REQ-027 SHALL, in BUSY, decrement cnt each cycle and return to IDLE on the edge where cnt==0.
REQ-028 SHALL make md_busy registered and equal to (state==BUSY), high for exactly N cycles following the start cycle.
REQ-029 SHALL, when ex_md_start is valid in BUSY, ignore it (no reload) and set md_err=1 until reset.
REQ-030 SHALL increment stall_cnt on each clock edge with stall=1, saturating at 16'hFFFF with no wrap.
REQ-031 SHALL accept MULT_CYCLES and DIV_CYCLES >= 1; a value of 1 gives a single md_busy cycle.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=IDLE, cnt=0, md_busy=0, md_err=0 and stall_cnt=0.
REQ-033 SHALL make stall and id_ex_flush depend only on current inputs and md_busy, so both are 0 during reset unless a data hazard is present.
REQ-034 SHALL, on reset mid-operation, abort a BUSY count immediately, with no residual busy after release.

Structure
REQ-035 SHALL place the ex_md_start encodings, the FSM state encoding and the Tuse-unused constant (3) in a shared pipeline package.
REQ-036 SHALL implement the busy FSM and counter as one sub-module, md_busy_timer; the hazard comparators remain in the top level.

Verification
REQ-037 SHALL test load-use: ex_dst=5, ex_tnew=2, id_rs=5, id_rs_tuse=1 -> stall=1, id_ex_flush=1, stall_cnt increments.
REQ-038 SHALL test register 0: id_rs=0, ex_dst=0, ex_tnew=2 -> stall=0.
REQ-039 SHALL test mult timing: ex_md_start=01 at edge t -> md_busy=1 for edges t+1..t+5, 0 at t+6; with id_is_md=1, stall=1 throughout that window.
REQ-040 SHALL test restart: ex_md_start=10 while BUSY -> cnt unchanged, md_err=1 and remaining asserted.
REQ-041 SHALL test async reset: reset low at cycle 3 of a div -> md_busy=0 immediately, md_err=0, stall_cnt=0.
REQ-042 SHALL test saturation: stall held for 70000 cycles -> stall_cnt=16'hFFFF.
